// File: rtl/adc_acq_pkg.sv
// ============================================================================
// adc_acq_pkg : shared types, framing constants and checksum fold for adc_acq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_TRAILER = 3'd3,
    ST_DONE    = 3'd4
  } acq_state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [7:0] TRL_MAGIC = 8'h5A;

  localparam int HDR_FILL_LSB = 0;
  localparam int HDR_N_LSB    = 24;
  localparam int HDR_ADR_LSB  = 48;
  localparam int HDR_TYPE_LSB = 72;
  localparam int HDR_TAG_LSB  = 74;
  localparam int MAGIC_LSB    = 120;

  localparam int TRL_CSUM_LSB = 0;
  localparam int TRL_DROP_LSB = 32;
  localparam int TRL_OVF_BIT  = 48;

  localparam int DROP_W     = 16;
  localparam int CSUM_W     = 32;
  // Widest output word the checksum fold accepts; narrower words are zero-padded.
  localparam int FOLD_MAX_W = 512;

  function automatic logic [CSUM_W-1:0] fold32(input logic [FOLD_MAX_W-1:0] word);
    logic [CSUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_W / CSUM_W; i++) begin
      acc = acc ^ word[i*CSUM_W +: CSUM_W];
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_burst_packer.sv
// ============================================================================
// adc_burst_packer : shifts sample pairs into one output word, strobes word_done
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_burst_packer #(
  parameter int SAMPLE_W          = 12,
  parameter int SAMPLES_PER_BURST = 8,
  parameter int OUT_W             = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          capture_en,
  input  logic [2*(SAMPLE_W+1)-1:0]     pair_in,
  output logic [OUT_W-1:0]              word,
  output logic                          word_done
);

  localparam int FIELD_W = SAMPLE_W + 1;
  localparam int PAIRS   = SAMPLES_PER_BURST / 2;
  localparam int ASM_W   = SAMPLES_PER_BURST * FIELD_W;
  localparam int CNT_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

  logic [ASM_W-1:0]     asm_q, asm_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]     word_q, word_d;
  logic                 done_q, done_d;
  logic [2*FIELD_W-1:0] fields;

  always_comb begin
    // Input carries {ovr,sample}; the word wants the over-range bit at each field LSB.
    fields = {pair_in[FIELD_W +: SAMPLE_W], pair_in[2*FIELD_W-1],
              pair_in[SAMPLE_W-1:0],        pair_in[SAMPLE_W]};
    asm_d  = asm_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    done_d = 1'b0;
    if (clear) begin
      asm_d = '0;
      cnt_d = '0;
    end else if (capture_en) begin
      // Newest pair enters at the top so the oldest sample ends at bit 0.
      asm_d = asm_q >> (2 * FIELD_W);
      asm_d[ASM_W-1 -: 2*FIELD_W] = fields;
      if (cnt_q == LAST_PAIR) begin
        cnt_d              = '0;
        done_d             = 1'b1;
        word_d             = '0;
        word_d[ASM_W-1:0]  = asm_d;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q  <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      done_q <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      done_q <= done_d;
    end
  end

  assign word      = word_q;
  assign word_done = done_q;

endmodule

`default_nettype wire

// File: rtl/adc_acq_ctrl.sv
// ============================================================================
// adc_acq_ctrl : frames ADC bursts as header / data / checksum trailer words
// Option macro ADC_ACQ_DUMMY_DAT_EN adds dummy_sel counter-pattern data. Rev 1.0
// ============================================================================
`default_nettype none

module adc_acq_ctrl
  import adc_acq_pkg::*;
#(
  parameter int SAMPLE_W          = 12,
  parameter int SAMPLES_PER_BURST = 8,
  parameter int OUT_W             = 128,
  parameter int BURST_CNT_W       = 24
) (
  input  logic                         adc_clk,
  input  logic                         reset_n,
  input  logic                         acq_reset,
  input  logic                         acq_enable,
  input  logic                         acq_trig,
  input  logic [1:0]                   fill_type,
  input  logic [4*BURST_CNT_W-1:0]     num_bursts_cfg,
  input  logic [15:0]                  channel_tag,
  input  logic [BURST_CNT_W-1:0]       initial_fill_num,
  input  logic                         initial_fill_num_wr,
  input  logic [2*(SAMPLE_W+1)-1:0]    adc_dat,
`ifdef ADC_ACQ_DUMMY_DAT_EN
  input  logic                         dummy_sel,
`endif
  input  logic                         ddr3_wr_done,
  output logic [OUT_W-1:0]             out_dat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BURST_CNT_W-1:0]       fill_num,
  output logic [BURST_CNT_W-1:0]       burst_start_adr,
  output logic                         acq_done,
  output logic                         sm_idle,
  output logic                         overflow
);

  acq_state_e             state_q, state_d;
  logic [1:0]             fill_type_q, fill_type_d;
  logic [BURST_CNT_W-1:0] n_q, n_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURST_CNT_W-1:0] fill_num_q, fill_num_d;
  logic [BURST_CNT_W-1:0] adr_q, adr_d;
  logic [OUT_W-1:0]       out_dat_q, out_dat_d;
  logic                   out_valid_q, out_valid_d;
  logic                   dat_word_q, dat_word_d;
  logic                   trl_loaded_q, trl_loaded_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [CSUM_W-1:0]      csum_q, csum_d;
  logic                   acq_done_q, acq_done_d;
  logic                   sm_idle_q, sm_idle_d;

  logic                      trig_fire;
  logic [2*(SAMPLE_W+1)-1:0] pair;
  logic [OUT_W-1:0]          pk_word;
  logic                      pk_done;

  assign trig_fire = (state_q == ST_ARMED) && acq_enable && acq_trig && !acq_reset;

`ifdef ADC_ACQ_DUMMY_DAT_EN
  logic [SAMPLE_W-1:0] dummy_cnt_q, dummy_cnt_d;

  always_comb dummy_cnt_d = trig_fire ? '0 : dummy_cnt_q + 1'b1;

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) dummy_cnt_q <= '0;
    else          dummy_cnt_q <= dummy_cnt_d;
  end

  assign pair = dummy_sel ? {1'b0, ~dummy_cnt_q, 1'b0, dummy_cnt_q} : adc_dat;
`else
  assign pair = adc_dat;
`endif

  adc_burst_packer #(
    .SAMPLE_W          (SAMPLE_W),
    .SAMPLES_PER_BURST (SAMPLES_PER_BURST),
    .OUT_W             (OUT_W)
  ) u_packer (
    .clk        (adc_clk),
    .rst_n      (reset_n),
    .clear      (trig_fire),
    .capture_en (state_q == ST_CAPTURE),
    .pair_in    (pair),
    .word       (pk_word),
    .word_done  (pk_done)
  );

  logic                   accept;
  logic [FOLD_MAX_W-1:0]  fold_in;
  logic [BURST_CNT_W-1:0] cfg_n;
  logic [BURST_CNT_W-1:0] drop_ext;
  logic [OUT_W-1:0]       hdr_word, trl_word;

  always_comb begin
    state_d      = state_q;
    fill_type_d  = fill_type_q;
    n_d          = n_q;
    burst_cnt_d  = burst_cnt_q;
    fill_num_d   = fill_num_q;
    adr_d        = adr_q;
    out_dat_d    = out_dat_q;
    out_valid_d  = out_valid_q;
    dat_word_d   = dat_word_q;
    trl_loaded_d = trl_loaded_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    csum_d       = csum_q;

    accept                = out_valid_q && out_ready;
    fold_in               = '0;
    fold_in[OUT_W-1:0]    = out_dat_q;
    cfg_n                 = num_bursts_cfg[fill_type*BURST_CNT_W +: BURST_CNT_W];
    drop_ext              = '0;
    drop_ext[DROP_W-1:0]  = drop_cnt_q;

    // Only data words that actually leave the register contribute to the checksum.
    if (accept) begin
      out_valid_d = 1'b0;
      if (dat_word_q) csum_d = csum_q ^ fold32(fold_in);
    end

    hdr_word = '0;
    hdr_word[HDR_FILL_LSB +: BURST_CNT_W] = fill_num_q;
    hdr_word[HDR_N_LSB    +: BURST_CNT_W] = cfg_n;
    hdr_word[HDR_ADR_LSB  +: BURST_CNT_W] = adr_q;
    hdr_word[HDR_TYPE_LSB +: 2]           = fill_type;
    hdr_word[HDR_TAG_LSB  +: 16]          = channel_tag;
    hdr_word[MAGIC_LSB    +: 8]           = HDR_MAGIC;

    trl_word = '0;
    trl_word[TRL_CSUM_LSB +: CSUM_W] = csum_d;
    trl_word[TRL_DROP_LSB +: DROP_W] = drop_cnt_q;
    trl_word[TRL_OVF_BIT]            = overflow_q;
    trl_word[MAGIC_LSB +: 8]         = TRL_MAGIC;

    if (acq_reset) begin
      state_d      = ST_IDLE;
      out_valid_d  = 1'b0;
      trl_loaded_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (initial_fill_num_wr) begin
            fill_num_d = initial_fill_num;
            adr_d      = '0;
          end
          if (acq_enable) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (!acq_enable) begin
            state_d = ST_IDLE;
          end else if (acq_trig) begin
            fill_type_d = fill_type;
            n_d         = cfg_n;
            burst_cnt_d = '0;
            out_dat_d   = hdr_word;
            out_valid_d = 1'b1;
            dat_word_d  = 1'b0;
            overflow_d  = 1'b0;
            drop_cnt_d  = '0;
            csum_d      = '0;
            state_d     = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (n_q == '0) begin
            state_d = ST_TRAILER;
          end else if (pk_done) begin
            if (!out_valid_q || accept) begin
              out_dat_d   = pk_word;
              out_valid_d = 1'b1;
              dat_word_d  = 1'b1;
            end else begin
              overflow_d = 1'b1;
              if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
            end
            // Dropped bursts still count, so the fill length never stretches.
            burst_cnt_d = burst_cnt_q + 1'b1;
            if (burst_cnt_d == n_q) state_d = ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          if (!trl_loaded_q) begin
            if (!out_valid_q || accept) begin
              out_dat_d    = trl_word;
              out_valid_d  = 1'b1;
              dat_word_d   = 1'b0;
              trl_loaded_d = 1'b1;
            end
          end else if (accept) begin
            trl_loaded_d = 1'b0;
            fill_num_d   = fill_num_q + 1'b1;
            adr_d        = adr_q + n_q + BURST_CNT_W'(2) - drop_ext;
            state_d      = ST_DONE;
          end
        end
        ST_DONE: begin
          if (ddr3_wr_done) state_d = acq_enable ? ST_ARMED : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    sm_idle_d  = (state_d == ST_IDLE);
    acq_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      fill_type_q  <= '0;
      n_q          <= '0;
      burst_cnt_q  <= '0;
      fill_num_q   <= '0;
      adr_q        <= '0;
      out_dat_q    <= '0;
      out_valid_q  <= 1'b0;
      dat_word_q   <= 1'b0;
      trl_loaded_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      csum_q       <= '0;
      acq_done_q   <= 1'b0;
      sm_idle_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      fill_type_q  <= fill_type_d;
      n_q          <= n_d;
      burst_cnt_q  <= burst_cnt_d;
      fill_num_q   <= fill_num_d;
      adr_q        <= adr_d;
      out_dat_q    <= out_dat_d;
      out_valid_q  <= out_valid_d;
      dat_word_q   <= dat_word_d;
      trl_loaded_q <= trl_loaded_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      csum_q       <= csum_d;
      acq_done_q   <= acq_done_d;
      sm_idle_q    <= sm_idle_d;
    end
  end

  assign out_dat         = out_dat_q;
  assign out_valid       = out_valid_q;
  assign fill_num        = fill_num_q;
  assign burst_start_adr = adr_q;
  assign acq_done        = acq_done_q;
  assign sm_idle         = sm_idle_q;
  assign overflow        = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_acq_ctrl.sv
// ============================================================================
// tb_adc_acq_ctrl : scoreboard bench for adc_acq_ctrl with a fill-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_acq_ctrl;

  localparam int SW  = 12;
  localparam int SPB = 8;
  localparam int OW  = 128;
  localparam int BCW = 24;
  localparam int FW  = SW + 1;
  localparam int P   = SPB / 2;

  logic              adc_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              acq_reset = 1'b0;
  logic              acq_enable = 1'b0;
  logic              acq_trig = 1'b0;
  logic [1:0]        fill_type = 2'd0;
  logic [4*BCW-1:0]  num_bursts_cfg = '0;
  logic [15:0]       channel_tag = 16'hC3E1;
  logic [BCW-1:0]    initial_fill_num = '0;
  logic              initial_fill_num_wr = 1'b0;
  logic [2*FW-1:0]   adc_dat = '0;
`ifdef ADC_ACQ_DUMMY_DAT_EN
  logic              dummy_sel = 1'b0;
`endif
  logic              ddr3_wr_done = 1'b0;
  logic [OW-1:0]     out_dat;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [BCW-1:0]    fill_num;
  logic [BCW-1:0]    burst_start_adr;
  logic              acq_done;
  logic              sm_idle;
  logic              overflow;

  adc_acq_ctrl #(
    .SAMPLE_W(SW), .SAMPLES_PER_BURST(SPB), .OUT_W(OW), .BURST_CNT_W(BCW)
  ) dut (
    .adc_clk             (adc_clk),
    .reset_n             (reset_n),
    .acq_reset           (acq_reset),
    .acq_enable          (acq_enable),
    .acq_trig            (acq_trig),
    .fill_type           (fill_type),
    .num_bursts_cfg      (num_bursts_cfg),
    .channel_tag         (channel_tag),
    .initial_fill_num    (initial_fill_num),
    .initial_fill_num_wr (initial_fill_num_wr),
    .adc_dat             (adc_dat),
`ifdef ADC_ACQ_DUMMY_DAT_EN
    .dummy_sel           (dummy_sel),
`endif
    .ddr3_wr_done        (ddr3_wr_done),
    .out_dat             (out_dat),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .fill_num            (fill_num),
    .burst_start_adr     (burst_start_adr),
    .acq_done            (acq_done),
    .sm_idle             (sm_idle),
    .overflow            (overflow)
  );

  always #5 adc_clk = ~adc_clk;

  int            checks = 0;
  int            errors = 0;
  logic [OW-1:0] exp_q[$];
  bit            hold_chk_en = 1'b1;
  logic [BCW-1:0] fill_num_m = '0;
  logic [BCW-1:0] adr_m = '0;

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: pops one expected word per handshake and checks hold stability.
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_dat = '0;
  logic [OW-1:0] mon_exp;
  always @(negedge adc_clk) begin
    if (reset_n && hold_chk_en && prev_hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_dat", out_dat, prev_dat);
    end
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got=%0h exp=none", out_dat);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_word", out_dat, mon_exp);
      end
    end
    prev_hold = reset_n && out_valid && !out_ready && !acq_reset;
    prev_dat  = out_dat;
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  function automatic logic [31:0] fold(input logic [OW-1:0] w);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < OW / 32; i++) acc = acc ^ w[i*32 +: 32];
    return acc;
  endfunction

  // One fill: out_ready is low for the first m*P+2 cycles after the trigger,
  // which holds the header long enough that exactly the first m words are lost.
  task automatic run_fill(input int ft, input int n, input int m_in, input bit ramp);
    logic [2*FW-1:0] pairs[$];
    logic [2*FW-1:0] pr;
    logic [OW-1:0]   w, hdr, trl;
    logic [31:0]     cs;
    int              m, drops, lim, c, s0;
    bit              done;
    m = (n == 0) ? 0 : ((m_in > n) ? n : m_in);
    drops = m;
    lim   = (m > 0) ? m * P + 2 : 0;
    num_bursts_cfg[ft*BCW +: BCW] = BCW'(n);
    fill_type = 2'(ft);
    check("armed_before_trig", {acq_done, sm_idle}, 0);

    hdr = '0;
    hdr[23:0]    = fill_num_m;
    hdr[47:24]   = BCW'(n);
    hdr[71:48]   = adr_m;
    hdr[73:72]   = 2'(ft);
    hdr[89:74]   = channel_tag;
    hdr[127:120] = 8'hA5;
    exp_q.push_back(hdr);

    cs = '0;
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int j = 0; j < P; j++) begin
        s0 = (k * P + j) * 2;
        if (ramp) pr = {1'b0, SW'(s0 + 1), 1'b0, SW'(s0)};
        else      pr = (2*FW)'($urandom);
        pairs.push_back(pr);
        w[(2*j)*FW   +: FW] = {pr[SW-1:0], pr[SW]};
        w[(2*j+1)*FW +: FW] = {pr[FW +: SW], pr[2*FW-1]};
      end
      if (k >= drops) begin
        exp_q.push_back(w);
        cs = cs ^ fold(w);
      end
    end
    trl = '0;
    trl[31:0]    = cs;
    trl[47:32]   = 16'(drops);
    trl[48]      = (drops > 0);
    trl[127:120] = 8'h5A;
    exp_q.push_back(trl);

    acq_trig  = 1'b1;
    out_ready = (lim == 0);
    tick();
    acq_trig = 1'b0;
    c = 1;
    done = 1'b0;
    while (!done && c < 400) begin
      adc_dat   = (c - 1 < pairs.size()) ? pairs[c-1] : (2*FW)'($urandom);
      out_ready = (c > lim);
      tick();
      done = acq_done;
      c++;
    end
    out_ready = 1'b1;
    check("done_reached", done, 1);

    fill_num_m = fill_num_m + 1'b1;
    adr_m      = adr_m + BCW'(n) + BCW'(2) - BCW'(drops);
    check("fill_num", fill_num, fill_num_m);
    check("burst_start_adr", burst_start_adr, adr_m);
    check("overflow", overflow, drops > 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic release_done();
    ddr3_wr_done = 1'b1;
    tick();
    ddr3_wr_done = 1'b0;
    check("left_done", acq_done, 0);
    check("rearmed_not_idle", sm_idle, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ft, n, m;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_acq_done", acq_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_dat", out_dat, 0);
    check("rst_fill_num", fill_num, 0);
    check("rst_adr", burst_start_adr, 0);
    check("rst_sm_idle", sm_idle, 1);

    initial_fill_num = 24'd5;
    initial_fill_num_wr = 1'b1;
    tick();
    initial_fill_num_wr = 1'b0;
    fill_num_m = 24'd5;
    adr_m = '0;
    check("preset_fill_num", fill_num, fill_num_m);

    acq_enable = 1'b1;
    tick();
    check("armed_sm_idle", sm_idle, 0);
    initial_fill_num = 24'd99;
    initial_fill_num_wr = 1'b1;
    tick();
    initial_fill_num_wr = 1'b0;
    check("preset_ignored_armed", fill_num, fill_num_m);

    run_fill(0, 2, 0, 1'b1);
    release_done();
    run_fill(1, 4, 2, 1'b0);
    release_done();
    run_fill(3, 0, 0, 1'b0);
    release_done();

    for (int r = 0; r < 8; r++) begin
      ft = int'($urandom_range(3, 0));
      n  = int'($urandom_range(5, 0));
      m  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(n, 0)) : 0;
      run_fill(ft, n, m, 1'b0);
      release_done();
    end

    // Synchronous abort in the middle of a capture.
    num_bursts_cfg[2*BCW +: BCW] = BCW'(8);
    fill_type = 2'd2;
    out_ready = 1'b0;
    acq_trig = 1'b1;
    tick();
    acq_trig = 1'b0;
    repeat (6) tick();
    acq_reset = 1'b1;
    tick();
    acq_reset = 1'b0;
    check("abort_sm_idle", sm_idle, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_fill_num", fill_num, fill_num_m);
    check("abort_adr", burst_start_adr, adr_m);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset mid-fill, sampled before the next clock edge.
    out_ready = 1'b0;
    acq_trig = 1'b1;
    tick();
    acq_trig = 1'b0;
    repeat (9) tick();
    hold_chk_en = 1'b0;
    #2;
    reset_n = 1'b0;
    acq_enable = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_acq_done", acq_done, 0);
    check("arst_overflow", overflow, 0);
    check("arst_out_dat", out_dat, 0);
    check("arst_fill_num", fill_num, 0);
    check("arst_adr", burst_start_adr, 0);
    check("arst_sm_idle", sm_idle, 1);
    tick();
    reset_n = 1'b1;
    tick();
    hold_chk_en = 1'b1;
    fill_num_m = '0;
    adr_m = '0;

    initial_fill_num = 24'd7;
    initial_fill_num_wr = 1'b1;
    tick();
    initial_fill_num_wr = 1'b0;
    fill_num_m = 24'd7;
    check("preset7_fill_num", fill_num, fill_num_m);
    out_ready = 1'b1;
    acq_enable = 1'b1;
    tick();

    // Back-to-back fills; a trigger while in DONE must be ignored.
    run_fill(1, 1, 0, 1'b0);
    acq_trig = 1'b1;
    tick();
    acq_trig = 1'b0;
    repeat (4) tick();
    check("done_trig_ignored", acq_done, 1);
    check("done_fill_num8", fill_num, 24'd8);
    check("done_no_words", out_valid, 0);
    release_done();
    run_fill(2, 3, 1, 1'b0);
    release_done();
    check("second_fill_num9", fill_num, 24'd9);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
